// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the device over the shared
// open-drain clock/data pair: inhibit, request-to-send, 8 data bits LSB first, odd parity,
// stop bit, then waits for the device ack and an idle bus.
// Optional feature: define PS2_TX_ACK_CHECK_EN to turn a missing device ack into an error.
module ps2_host_transmitter #(
  parameter int unsigned ClkFrequency   = 100_000_000,
  parameter int unsigned InhibitUs      = 100,
  parameter int unsigned StartTimeoutUs = 15000,
  parameter int unsigned FrameTimeoutUs = 2000,
  parameter int unsigned FilterLen      = 8
) (
  input  logic       clk100M,
  input  logic       rst,
  input  logic       txValid,
  input  logic [7:0] txData,
  output logic       txReady,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkDrvLow,
  output logic       ps2DataDrvLow,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CyclesPerUs   = ClkFrequency / 1_000_000;
  localparam int unsigned InhibitCycles = CyclesPerUs * InhibitUs;
  localparam int unsigned StartCycles   = CyclesPerUs * StartTimeoutUs;
  localparam int unsigned FrameCycles   = CyclesPerUs * FrameTimeoutUs;
  localparam int unsigned MaxCycles0    = (InhibitCycles > StartCycles) ? InhibitCycles
                                                                        : StartCycles;
  localparam int unsigned MaxCycles     = (MaxCycles0 > FrameCycles) ? MaxCycles0 : FrameCycles;
  localparam int unsigned TimerW        = $clog2(MaxCycles + 1);
  localparam int unsigned FiltW         = $clog2(FilterLen + 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StStart,
    StWait,
    StShift,
    StAck,
    StDone,
    StErr
  } state_e;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]       sync1_q, sync2_q, filt_q;
  logic [FiltW-1:0] filt_cnt_q [2];
  logic             clk_filt_prev_q;
  logic             fall;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              data_low_q, data_low_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              parity_q, parity_d;
`ifdef PS2_TX_ACK_CHECK_EN
  logic              ack_q, ack_d;
`endif

  // Synchronise both pins and accept a level change only after FilterLen equal samples.
  always_ff @(posedge clk100M or negedge rst) begin
    if (!rst) begin
      sync1_q         <= 2'b11;
      sync2_q         <= 2'b11;
      filt_q          <= 2'b11;
      clk_filt_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) filt_cnt_q[i] <= '0;
    end else begin
      sync1_q         <= {ps2DataIn, ps2ClkIn};
      sync2_q         <= sync1_q;
      clk_filt_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (filt_cnt_q[i] == FiltW'(FilterLen - 1)) begin
            filt_q[i]     <= sync2_q[i];
            filt_cnt_q[i] <= '0;
          end else begin
            filt_cnt_q[i] <= filt_cnt_q[i] + FiltW'(1);
          end
        end else begin
          filt_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign fall = clk_filt_prev_q & ~filt_q[0];

  // FSM and datapath state registers.
  always_ff @(posedge clk100M or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      data_low_q <= 1'b0;
      tx_data_q  <= '0;
      parity_q   <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_q      <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      data_low_q <= data_low_d;
      tx_data_q  <= tx_data_d;
      parity_q   <= parity_d;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_q      <= ack_d;
`endif
    end
  end

  // Next-state logic; the shared timer counts down and saturates at zero.
  always_comb begin
    state_d    = state_q;
    timer_d    = (timer_q != '0) ? timer_q - TimerW'(1) : timer_q;
    bit_cnt_d  = bit_cnt_q;
    data_low_d = data_low_q;
    tx_data_d  = tx_data_q;
    parity_d   = parity_q;
`ifdef PS2_TX_ACK_CHECK_EN
    ack_d      = ack_q;
`endif
    unique case (state_q)
      StIdle: begin
        data_low_d = 1'b0;
        if (txValid) begin
          tx_data_d = txData;
          parity_d  = ~^txData;
          timer_d   = TimerW'(InhibitCycles - 1);
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (timer_q == '0) begin
          data_low_d = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        timer_d = TimerW'(StartCycles - 1);
        state_d = StWait;
      end
      StWait: begin
        if (timer_q == '0) begin
          state_d = StErr;
        end else if (fall) begin
          data_low_d = ~tx_data_q[0];
          bit_cnt_d  = 4'd1;
          timer_d    = TimerW'(FrameCycles - 1);
          state_d    = StShift;
        end
      end
      StShift: begin
        if (timer_q == '0) begin
          state_d = StErr;
        end else if (fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            data_low_d = ~tx_data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            data_low_d = ~parity_q;
          end else if (bit_cnt_q == 4'd9) begin
            data_low_d = 1'b0;
          end else begin
`ifdef PS2_TX_ACK_CHECK_EN
            ack_d = filt_q[1];
`endif
            state_d = StAck;
          end
        end
      end
      StAck: begin
        if (timer_q == '0) begin
          state_d = StErr;
        end else if (filt_q == 2'b11) begin
`ifdef PS2_TX_ACK_CHECK_EN
          state_d = ack_q ? StErr : StDone;
`else
          state_d = StDone;
`endif
        end
      end
      StDone, StErr: begin
        data_low_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Drives decode straight from state so an async reset releases both lines at once.
  always_comb begin
    txReady       = (state_q == StIdle);
    busy          = (state_q != StIdle);
    done          = (state_q == StDone);
    error         = (state_q == StErr);
    ps2ClkDrvLow  = (state_q == StInhibit) || (state_q == StStart);
    ps2DataDrvLow = data_low_q &&
                    ((state_q == StStart) || (state_q == StWait) || (state_q == StShift));
  end

endmodule
